// File: rtl/ada_sample_fifo_pkg.sv
// Shared bus/register definitions for the sample FIFO: offsets, field positions, access codes.
package ada_sample_fifo_pkg;

    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;
    localparam int SAMPLE_W      = 24;

    // Access size codes on acc
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = 2'd2;

    localparam int REG_DATA = 0;
    localparam int REG_STAT = 4;
    localparam int REG_CTRL = 8;

    localparam int DATA_VALID_BIT   = 31;
    localparam int STAT_OVF_BIT     = 16;
    localparam int STAT_FULL_BIT    = 9;
    localparam int STAT_EMPTY_BIT   = 8;
    localparam int STAT_CNT_W       = 8;
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/ada_fifo_mem.sv
// Sample storage: synchronous write, combinational read. Deliberately unreset;
// the pointers alone define which entries are live.
module ada_fifo_mem
    import ada_sample_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic signed [SAMPLE_W-1:0] wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic signed [SAMPLE_W-1:0] rdata_o
);

    logic signed [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ada_sample_fifo.sv
// Sample FIFO with a small register bus: DATA pops the head, STAT reports
// occupancy/overflow, CTRL flushes and clears the sticky overflow flag.
module ada_sample_fifo
    import ada_sample_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int VA_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       arrive,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [VA_WIDTH-1:0]        addr,
    input  logic                       w_rb,
    input  logic [BUS_ACC_WIDTH-1:0]   acc,
    input  logic [BUS_WIDTH-1:0]       wdata,
    input  logic                       req,
    output logic [BUS_WIDTH-1:0]       rdata,
    output logic                       resp,
    output logic                       fault,
    output logic                       irq,
    output logic                       ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int HALF  = DEPTH / 2;

    logic [PTR_W:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic                       ovf_q, ovf_d, irq_q, resp_q;
    logic [BUS_WIDTH-1:0]       rdata_q, rdata_d, stat_w;
    logic [PTR_W:0]             count;
    logic                       full, empty;
    logic                       sel_data, sel_stat, sel_ctrl, invalid, vreq;
    logic                       rd_data, rd_stat, wr_ctrl, flush, clr_ovf;
    logic                       push, pop, lost;
    logic signed [SAMPLE_W-1:0] head;
    logic                       unused_wdata;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

    assign sel_data = (addr == VA_WIDTH'(REG_DATA));
    assign sel_stat = (addr == VA_WIDTH'(REG_STAT));
    assign sel_ctrl = (addr == VA_WIDTH'(REG_CTRL));
    assign invalid  = !(sel_data || sel_stat || sel_ctrl) || (acc != ACC_4B) ||
                      (w_rb && (sel_data || sel_stat)) || (!w_rb && sel_ctrl);
    assign fault    = req && invalid;
    assign vreq     = req && !invalid;

    assign rd_data = vreq && !w_rb && sel_data;
    assign rd_stat = vreq && !w_rb && sel_stat;
    assign wr_ctrl = vreq && w_rb && sel_ctrl;
    assign flush   = wr_ctrl && wdata[CTRL_FLUSH_BIT];
    assign clr_ovf = wr_ctrl && wdata[CTRL_CLR_OVF_BIT];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
    assign pop  = rd_data && !empty;
    assign push = arrive && (!full || pop) && !flush;
    assign lost = arrive && full && !pop && !flush;

    assign unused_wdata = ^wdata[BUS_WIDTH-1:2];

    ada_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wptr_q[PTR_W-1:0]),
        .wdata_i (sample),
        .raddr_i (rptr_q[PTR_W-1:0]),
        .rdata_o (head)
    );

    always_comb begin
        stat_w                       = '0;
        stat_w[STAT_OVF_BIT]         = ovf_q;
        stat_w[STAT_FULL_BIT]        = full;
        stat_w[STAT_EMPTY_BIT]       = empty;
        stat_w[STAT_CNT_W-1:0]       = STAT_CNT_W'(count);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        rdata_d = rdata_q;

        if (flush) begin
            rptr_d = wptr_q;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
        end

        if (clr_ovf) ovf_d = 1'b0;
        if (lost)    ovf_d = 1'b1;

        if (rd_data) begin
            rdata_d = '0;
            if (!empty) begin
                rdata_d[SAMPLE_W-1:0]   = head;
                rdata_d[DATA_VALID_BIT] = 1'b1;
            end
        end else if (rd_stat) begin
            rdata_d = stat_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            irq_q   <= (int'(count) >= HALF) || ovf_q;
            resp_q  <= vreq;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign resp  = resp_q;
    assign irq   = irq_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_ada_sample_fifo.sv
// Directed + randomized bench for ada_sample_fifo against a queue-based reference model.
module tb_ada_sample_fifo;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        arrive = 1'b0;
    logic [23:0] sample = '0;
    logic [3:0]  addr = '0;
    logic        w_rb = 1'b0;
    logic [1:0]  acc = 2'd2;
    logic [31:0] wdata = '0;
    logic        req = 1'b0;
    logic [31:0] rdata;
    logic        resp, fault, irq, ovf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [23:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_irq = 1'b0;
    logic        m_resp = 1'b0;
    logic [31:0] m_rdata = '0;

    ada_sample_fifo #(.DEPTH(16), .VA_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn), .arrive(arrive), .sample(sample),
        .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
        .rdata(rdata), .resp(resp), .fault(fault), .irq(irq), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check fault, let the edge happen, update model, compare.
    task automatic step(input logic rn, input logic arr, input logic [23:0] smp,
                        input logic rq, input logic [3:0] ad, input logic wr,
                        input logic [1:0] ac, input logic [31:0] wd);
        logic        inv, ok, nirq;
        logic [31:0] st;
        rstn = rn; arrive = arr; sample = smp; req = rq;
        addr = ad; w_rb = wr; acc = ac; wdata = wd;
        inv = !(ad == 4'd0 || ad == 4'd4 || ad == 4'd8) || (ac != 2'd2) ||
              (wr && ad != 4'd8) || (!wr && ad == 4'd8);
        #1;
        chk("fault", {31'b0, fault}, {31'b0, rq & inv});
        @(posedge clk);
        nirq = (mq.size() >= 8) || m_ovf;
        if (!rn) begin
            mq.delete();
            m_ovf = 1'b0; nirq = 1'b0; m_resp = 1'b0; m_rdata = '0;
        end else begin
            ok = rq && !inv;
            m_resp = ok;
            st = {15'b0, m_ovf, 6'b0, (mq.size() == 16), (mq.size() == 0), 8'(mq.size())};
            if (ok && !wr && ad == 4'd0)
                m_rdata = (mq.size() > 0) ? (32'h8000_0000 | {8'h00, mq.pop_front()}) : 32'h0;
            else if (ok && !wr && ad == 4'd4)
                m_rdata = st;
            if (ok && wr && wd[1]) m_ovf = 1'b0;
            if (ok && wr && wd[0]) mq.delete();
            else if (arr) begin
                if (mq.size() < 16) mq.push_back(smp);
                else m_ovf = 1'b1;
            end
        end
        m_irq = nirq;
        #1;
        chk("resp", {31'b0, resp}, {31'b0, m_resp});
        chk("rdata", rdata, m_rdata);
        chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        @(negedge clk);
    endtask

    task automatic idle();                   step(1, 0, 0, 0, 0, 0, 2, 0); endtask
    task automatic push(input logic [23:0] s); step(1, 1, s, 0, 0, 0, 2, 0); endtask
    task automatic rd(input logic [3:0] a);   step(1, 0, 0, 1, a, 0, 2, 0); endtask
    task automatic wctrl(input logic [31:0] v); step(1, 0, 0, 1, 8, 1, 2, v); endtask

    initial begin
        logic [23:0] s, x;
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 0, 0, 2, 0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", {31'b0, resp}, 32'h0);
        rd(4);
        chk("rst_stat", rdata, 32'h0000_0100);

        // Single push then DATA read
        push(24'h123456);
        rd(0);
        chk("one_data", rdata, 32'h8012_3456);
        chk("one_resp", {31'b0, resp}, 32'h1);
        idle();
        chk("one_resp_drop", {31'b0, resp}, 32'h0);
        rd(4);
        chk("one_stat", rdata, 32'h0000_0100);

        // Overflow: 17 arrivals, then drain in order
        for (int i = 1; i <= 17; i++) push(24'(i));
        rd(4);
        chk("ovf_stat", rdata, 32'h0001_0210);
        chk("ovf_irq", {31'b0, irq}, 32'h1);
        for (int i = 1; i <= 16; i++) begin
            rd(0);
            chk("ovf_order", rdata, 32'h8000_0000 | 32'(i));
        end
        wctrl(32'h2);

        // Full FIFO: arrive and pop together
        for (int i = 0; i < 16; i++) begin
            s = 24'($urandom);
            push(s);
        end
        x = 24'($urandom);
        step(1, 1, x, 1, 0, 0, 2, 0);
        rd(4);
        chk("full_pp_stat", rdata, 32'h0000_0210);
        for (int i = 0; i < 16; i++) rd(0);
        chk("full_pp_last", rdata, 32'h8000_0000 | {8'h00, x});

        // Empty read and illegal accesses
        rd(0);
        chk("empty_data", rdata, 32'h0);
        push(24'hABCDEF);
        step(1, 0, 0, 1, 0, 0, 1, 0);
        chk("acc2b_fault_resp", {31'b0, resp}, 32'h0);
        step(1, 0, 0, 1, 0, 1, 2, 32'h5);
        step(1, 0, 0, 1, 8, 0, 2, 0);
        step(1, 0, 0, 1, 12, 0, 2, 0);
        rd(4);
        chk("nopop_stat", rdata, 32'h0000_0001);
        rd(0);
        chk("nopop_data", rdata, 32'h80AB_CDEF);

        // Flush + clear coincident with arrive on a full, overflowed FIFO
        for (int i = 0; i < 17; i++) push(24'($urandom));
        step(1, 1, 24'h777777, 1, 8, 1, 2, 32'h3);
        chk("flush_ovf", {31'b0, ovf}, 32'h0);
        rd(4);
        chk("flush_stat", rdata, 32'h0000_0100);
        chk("flush_irq", {31'b0, irq}, 32'h0);

        // Reset mid-operation with a read in flight
        for (int i = 0; i < 5; i++) push(24'($urandom));
        step(0, 0, 0, 1, 0, 0, 2, 0);
        chk("midrst_resp", {31'b0, resp}, 32'h0);
        rd(4);
        chk("midrst_stat", rdata, 32'h0000_0100);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            logic arr;
            arr = ($urandom_range(0, 9) < 6);
            s = 24'($urandom);
            op = $urandom_range(0, 7);
            if ($urandom_range(0, 199) == 0)
                step(0, arr, s, 0, 0, 0, 2, 0);
            else case (op)
                0, 1, 2: step(1, arr, s, 1, 0, 0, 2, 0);
                3:       step(1, arr, s, 1, 4, 0, 2, 0);
                4:       step(1, arr, s, 1, 8, 1, 2, 32'($urandom_range(0, 3)));
                5:       step(1, arr, s, 1, 4'($urandom), 1'($urandom), 2'($urandom), $urandom);
                default: step(1, arr, s, 0, 0, 0, 2, 0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
